irq_timer_ctrl: RTL

- Memory-mapped timer plus interrupt controller that produces the Interrupt input of the CPU control unit.
- Latches timer and external interrupt sources into a pending register and masks them.
- Raises Interrupt only while the CPU runs in user mode (PC_high=0), then holds off until the handler returns.
- Sits on the data bus beside data memory and decodes its own address window.

---
 rtl/irq_pkg.sv | 32 +++
 rtl/irq_timer_core.sv | 47 ++++
 rtl/irq_timer_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the timer/interrupt controller: register offsets,
// FSM encoding, TCON bit positions and a fixed-priority encoder.
package irq_pkg;

  localparam logic [2:0] OFF_TH    = 3'd0;
  localparam logic [2:0] OFF_TL    = 3'd1;
  localparam logic [2:0] OFF_TCON  = 3'd2;
  localparam logic [2:0] OFF_IMASK = 3'd3;
  localparam logic [2:0] OFF_IPEND = 3'd4;
  localparam logic [2:0] OFF_STATE = 3'd5;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_TF = 2;

  localparam logic [31:0] TL_MAX = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } irq_state_e;

  // Lowest set index wins; an all-zero vector yields 0.
  function automatic logic [2:0] lowest_set(input logic [7:0] vec);
    lowest_set = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) lowest_set = 3'(i);
    end
  endfunction

endpackage

// File: rtl/irq_timer_core.sv
// Free-running reload timer: TH/TL/TCON registers and the overflow request
// that feeds IPEND[0].
module irq_timer_core
  import irq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        th_we,
  input  logic        tl_we,
  input  logic        tcon_we,
  input  logic        tf_clr,
  input  logic [31:0] wdata,
  output logic [31:0] th,
  output logic [31:0] tl,
  output logic [2:0]  tcon,
  output logic        ovf_irq
);

  logic ovf;

  assign ovf     = tcon[TCON_EN] && (tl == TL_MAX);
  assign ovf_irq = ovf && tcon[TCON_IE];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, regardless of statement order inside the block.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th   <= '0;
      tl   <= '0;
      tcon <= '0;
    end else begin
      if (th_we) th <= wdata;

      // A software write to TL takes precedence over both reload and count.
      if (tl_we)               tl <= wdata;
      else if (ovf)            tl <= th;
      else if (tcon[TCON_EN])  tl <= tl + 32'd1;

      if (tcon_we) tcon[TCON_IE:TCON_EN] <= wdata[TCON_IE:TCON_EN];

      // Hardware set beats a simultaneous write-1-clear.
      if (ovf_irq)     tcon[TCON_TF] <= 1'b1;
      else if (tf_clr) tcon[TCON_TF] <= 1'b0;
    end
  end

endmodule

// File: rtl/irq_timer_ctrl.sv
// Memory-mapped timer plus interrupt controller: bus decode, pending/mask
// registers and the request FSM that drives the CPU's Interrupt input.
module irq_timer_ctrl
  import irq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          NUM_EXT   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  input  logic               MemWr,
  input  logic               MemRd,
  output logic [31:0]        rdata,
  input  logic [NUM_EXT-1:0] ext_irq,
  input  logic               PC_high,
  input  logic               irq_ack,
  output logic               Interrupt,
  output logic [2:0]         cause
);

  localparam int NSRC = NUM_EXT + 1;

  logic              sel;
  logic [2:0]        off;
  logic              wr;
  logic [31:0]       th;
  logic [31:0]       tl;
  logic [2:0]        tcon;
  logic              ovf_irq;
  logic [NSRC-1:0]   imask;
  logic [NSRC-1:0]   ipend;
  logic [NSRC-1:0]   active;
  logic [NSRC-1:0]   hw_set;
  logic [NSRC-1:0]   sw_clr;
  irq_state_e        state;
  logic              pc_high_q;
  logic              unused_ok;

  assign sel       = (addr[31:5] == BASE_ADDR[31:5]);
  assign off       = addr[4:2];
  assign wr        = MemWr && sel;
  assign unused_ok = &{1'b0, addr[1:0]};

  assign sw_clr = (wr && off == OFF_IPEND) ? wdata[NSRC-1:0] : '0;
  assign hw_set = {ext_irq, ovf_irq};
  assign active = ipend & imask;

  irq_timer_core u_core (
    .clk     (clk),
    .reset   (reset),
    .th_we   (wr && off == OFF_TH),
    .tl_we   (wr && off == OFF_TL),
    .tcon_we (wr && off == OFF_TCON),
    .tf_clr  (sw_clr[0]),
    .wdata   (wdata),
    .th      (th),
    .tl      (tl),
    .tcon    (tcon),
    .ovf_irq (ovf_irq)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      imask <= '0;
      ipend <= '0;
    end else begin
      if (wr && off == OFF_IMASK) imask <= wdata[NSRC-1:0];
      ipend <= (ipend & ~sw_clr) | hw_set;
    end
  end

  // SVC exits on the falling edge of PC_high, not its level, so the cycles
  // before the CPU actually enters the handler do not end service early.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      Interrupt <= 1'b0;
      cause     <= 3'd0;
      pc_high_q <= 1'b0;
    end else begin
      pc_high_q <= PC_high;
      case (state)
        IDLE: begin
          if (active != '0 && !PC_high) begin
            state     <= REQ;
            Interrupt <= 1'b1;
            cause     <= lowest_set(8'(active));
          end
        end
        REQ: begin
          if (irq_ack) begin
            state     <= SVC;
            Interrupt <= 1'b0;
          end else if (active == '0) begin
            state     <= IDLE;
            Interrupt <= 1'b0;
          end
        end
        SVC: begin
          if (pc_high_q && !PC_high) state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          Interrupt <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: rdata gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rdata = '0;
    if (sel && MemRd) begin
      case (off)
        OFF_TH:    rdata = th;
        OFF_TL:    rdata = tl;
        OFF_TCON:  rdata = {29'd0, tcon};
        OFF_IMASK: rdata = 32'(imask);
        OFF_IPEND: rdata = 32'(ipend);
        OFF_STATE: rdata = {30'd0, state};
        default:   rdata = '0;
      endcase
    end
  end

endmodule
